cram_backup: RTL and testbench

CRAM_BACKUP -- requirements
Module: cram_backup

---
 rtl/cram_backup.sv | 154 +++++++++++++++
 tb/tb_cram_backup.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cram_backup.sv
// Cartridge RAM backup engine: streams cart RAM to/from 512-byte storage sectors.
// A load or save request walks sectors 0..L, one strobe/ack handshake per sector.
module cram_backup (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        bk_ena,
  input  logic        bk_load,
  input  logic        bk_save,
  input  logic        downloading,
  input  logic        img_nonzero,
  input  logic [7:0]  cart_ram_size,
  input  logic        is_mbc2,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [7:0]  sd_buff_addr,
  input  logic [15:0] sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [15:0] sd_buff_din,
  output logic [15:0] bk_addr,
  output logic        bk_wr,
  output logic [15:0] bk_data,
  input  logic [15:0] bk_q,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] lba_q, lba_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic       loading_q, loading_d;
  logic       done_q, done_d;

  logic       load_q, save_q, dl_q, ack_q;

  logic       has_ram;
  logic [7:0] last_lba;
  logic       load_req, save_req, ack_rise, ack_fall;

  // Last sector index from the header RAM size code; MBC2 overrides the code.
  always_comb begin
    has_ram  = 1'b1;
    last_lba = 8'd0;
    if (is_mbc2) begin
      last_lba = 8'd1;
    end else begin
      case (cart_ram_size)
        8'd0:    has_ram  = 1'b0;
        8'd1:    last_lba = 8'd3;
        8'd2:    last_lba = 8'd15;
        8'd3:    last_lba = 8'd63;
        default: last_lba = 8'd255;
      endcase
    end
  end

  assign load_req = (bk_load & ~load_q) | (dl_q & ~downloading & img_nonzero);
  assign save_req = bk_save & ~save_q;
  assign ack_rise = sd_ack & ~ack_q;
  assign ack_fall = ~sd_ack & ack_q;

  always_comb begin
    // NOTE: every next-state signal gets a default before the case so no
    // path leaves one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    lba_d     = lba_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    loading_d = loading_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A simultaneous save is simply dropped in favour of the load.
        if (bk_ena && has_ram && (load_req || save_req)) begin
          state_d   = ST_REQ;
          lba_d     = 8'd0;
          loading_d = load_req;
          rd_d      = load_req;
          wr_d      = ~load_req;
        end
      end
      ST_REQ: begin
        if (ack_rise) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (ack_fall) begin
          if (lba_q >= last_lba) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            lba_d   = lba_q + 8'd1;
            rd_d    = loading_q;
            wr_d    = ~loading_q;
            state_d = ST_REQ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (reset) begin
      state_q   <= ST_IDLE;
      lba_q     <= 8'd0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      loading_q <= 1'b0;
      done_q    <= 1'b0;
      load_q    <= 1'b0;
      save_q    <= 1'b0;
      dl_q      <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lba_q     <= lba_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      loading_q <= loading_d;
      done_q    <= done_d;
      load_q    <= bk_load;
      save_q    <= bk_save;
      dl_q      <= downloading;
      ack_q     <= sd_ack;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign sd_rd       = rd_q;
  assign sd_wr       = wr_q;
  assign sd_lba      = {24'd0, lba_q};
  assign bk_addr     = {lba_q, sd_buff_addr};
  assign bk_data     = sd_buff_dout;
  assign sd_buff_din = bk_q;
  // Cart RAM is only ever written while loading from storage.
  assign bk_wr       = sd_buff_wr & sd_ack & loading_q & busy;

endmodule

// File: tb/tb_cram_backup.sv
// Self-checking bench for cram_backup: emulates the storage side and checks
// sector sequencing, strobes, address/data routing and done against a model.
module tb_cram_backup;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        bk_ena, bk_load, bk_save, downloading, img_nonzero;
  logic [7:0]  cart_ram_size;
  logic        is_mbc2;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_dout;
  logic        sd_buff_wr;
  logic [15:0] sd_buff_din, bk_addr, bk_data, bk_q;
  logic        bk_wr, busy, done;

  int errors = 0;
  int checks = 0;

  cram_backup dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .bk_ena       (bk_ena),
    .bk_load      (bk_load),
    .bk_save      (bk_save),
    .downloading  (downloading),
    .img_nonzero  (img_nonzero),
    .cart_ram_size(cart_ram_size),
    .is_mbc2      (is_mbc2),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .bk_addr      (bk_addr),
    .bk_wr        (bk_wr),
    .bk_data      (bk_data),
    .bk_q         (bk_q),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: number of sectors a cartridge needs (0 = no RAM).
  function automatic int exp_sectors(input bit mbc2, input int size);
    if (mbc2) return 2;
    if (size == 0) return 0;
    if (size >= 4) return 256;
    return 1 << (2 * size);
  endfunction

  task automatic pulse_load();
    @(negedge clk_sys) bk_load = 1'b1;
    @(negedge clk_sys) bk_load = 1'b0;
  endtask

  task automatic pulse_save();
    @(negedge clk_sys) bk_save = 1'b1;
    @(negedge clk_sys) bk_save = 1'b0;
  endtask

  // Wait for the sector strobe, check it, optionally stall, then acknowledge.
  task automatic start_sector(input bit exp_load, input int s, input int delay);
    int c = 0;
    while (!(sd_rd || sd_wr) && c < 20) begin
      @(negedge clk_sys);
      c++;
    end
    check("strobe_seen", 32'(sd_rd | sd_wr), 32'd1);
    check("sd_rd", 32'(sd_rd), 32'(exp_load));
    check("sd_wr", 32'(sd_wr), 32'(!exp_load));
    check("sd_lba", sd_lba, 32'(s));
    check("busy_req", 32'(busy), 32'd1);
    for (int d = 0; d < delay; d++) begin
      @(negedge clk_sys);
      check("strobe_hold", 32'(sd_rd | sd_wr), 32'd1);
    end
    sd_ack = 1'b1;
    @(negedge clk_sys);
    check("strobe_clr", 32'({sd_rd, sd_wr}), 32'd0);
    check("busy_xfer", 32'(busy), 32'd1);
  endtask

  // Edges that must be ignored while a transfer is in progress.
  task automatic inject_edges();
    @(negedge clk_sys);
    bk_load = 1'b1; bk_save = 1'b1; downloading = 1'b1;
    @(negedge clk_sys);
    bk_load = 1'b0; bk_save = 1'b0; downloading = 1'b0;
  endtask

  task automatic finish_sector(input bit exp_load, input int s, input int nwords);
    for (int w = 0; w < nwords; w++) begin
      logic [7:0] a;
      @(negedge clk_sys);
      a = (nwords == 256) ? 8'(w) : 8'($urandom_range(0, 255));
      sd_buff_addr = a;
      sd_buff_dout = 16'($urandom);
      bk_q         = 16'($urandom);
      sd_buff_wr   = 1'b1;
      #1;
      check("bk_wr", 32'(bk_wr), 32'(exp_load));
      check("bk_addr", 32'(bk_addr), 32'(s * 256 + int'(a)));
      check("bk_data", 32'(bk_data), 32'(sd_buff_dout));
      check("sd_buff_din", 32'(sd_buff_din), 32'(bk_q));
    end
    @(negedge clk_sys);
    sd_buff_wr = 1'b0;
    sd_ack     = 1'b0;
  endtask

  task automatic run_transfer(input bit exp_load, input int sectors, input int nwords,
                              input int inject_s, input bit drop_ena);
    for (int s = 0; s < sectors; s++) begin
      if (drop_ena && s == 1) bk_ena = 1'b0;
      start_sector(exp_load, s, int'($urandom_range(0, 2)));
      if (s == inject_s) inject_edges();
      finish_sector(exp_load, s, nwords);
      @(negedge clk_sys);
      if (s == sectors - 1) begin
        check("done_pulse", 32'(done), 32'd1);
        check("busy_end", 32'(busy), 32'd0);
        check("strobe_end", 32'({sd_rd, sd_wr}), 32'd0);
        @(negedge clk_sys);
        check("done_one_cycle", 32'(done), 32'd0);
      end else begin
        check("done_mid", 32'(done), 32'd0);
      end
    end
  endtask

  task automatic expect_idle(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk_sys);
      check(tag, 32'({busy, sd_rd, sd_wr, done}), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; bk_ena = 1'b1; bk_load = 1'b0; bk_save = 1'b0;
    downloading = 1'b0; img_nonzero = 1'b1; cart_ram_size = 8'd2; is_mbc2 = 1'b0;
    sd_ack = 1'b0; sd_buff_addr = 8'd0; sd_buff_dout = 16'd0; sd_buff_wr = 1'b0;
    bk_q = 16'd0;
    repeat (3) @(negedge clk_sys);
    check("rst_outputs", 32'({busy, sd_rd, sd_wr, done, bk_wr}), 32'd0);
    check("rst_lba", sd_lba, 32'd0);
    reset = 1'b0;

    // Save of a 16-sector image.
    cart_ram_size = 8'd2;
    pulse_save();
    run_transfer(1'b0, exp_sectors(1'b0, 2), 4, -1, 1'b0);
    expect_idle("idle_after_save", 3);

    // MBC2 load triggered by the end of a download, full 256-word sectors.
    is_mbc2 = 1'b1; cart_ram_size = 8'($urandom_range(0, 5));
    @(negedge clk_sys) downloading = 1'b1;
    repeat (3) @(negedge clk_sys);
    downloading = 1'b0;
    @(negedge clk_sys);
    run_transfer(1'b1, exp_sectors(1'b1, 0), 256, -1, 1'b0);
    expect_idle("idle_after_mbc2", 3);
    is_mbc2 = 1'b0;

    // Simultaneous load and save: load wins.
    cart_ram_size = 8'd3;
    @(negedge clk_sys) begin bk_load = 1'b1; bk_save = 1'b1; end
    @(negedge clk_sys) begin bk_load = 1'b0; bk_save = 1'b0; end
    run_transfer(1'b1, exp_sectors(1'b0, 3), 1, -1, 1'b0);

    // Requests ignored: bk_ena low, and no cart RAM.
    bk_ena = 1'b0;
    pulse_save();
    expect_idle("ignored_ena_low", 4);
    bk_ena = 1'b1;
    cart_ram_size = 8'd0;
    pulse_load();
    expect_idle("ignored_no_ram", 4);

    // Ack already high when the request starts is not a rising edge.
    cart_ram_size = 8'd1;
    @(negedge clk_sys) sd_ack = 1'b1;
    pulse_load();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_sys);
      check("stale_ack_wait", 32'({busy, sd_rd}), 32'd3);
    end
    sd_ack = 1'b0;
    @(negedge clk_sys);
    run_transfer(1'b1, exp_sectors(1'b0, 1), 2, -1, 1'b0);

    // Reset during the transfer of sector 7 aborts without done.
    cart_ram_size = 8'd3;
    pulse_load();
    for (int s = 0; s < 7; s++) begin
      start_sector(1'b1, s, 0);
      finish_sector(1'b1, s, 1);
      @(negedge clk_sys);
    end
    start_sector(1'b1, 7, 0);
    reset = 1'b1;
    @(negedge clk_sys);
    check("abort_outputs", 32'({busy, sd_rd, sd_wr, done}), 32'd0);
    check("abort_lba", sd_lba, 32'd0);
    sd_ack = 1'b0; reset = 1'b0;
    expect_idle("abort_no_done", 3);

    // Fresh load from sector 0; edges at sector 5 and bk_ena drop are ignored.
    pulse_load();
    run_transfer(1'b1, exp_sectors(1'b0, 3), 1, 5, 1'b1);
    expect_idle("idle_after_inject", 3);
    bk_ena = 1'b1;

    // Randomised transfers.
    for (int it = 0; it < 4; it++) begin
      int  size = int'($urandom_range(1, 6));
      bit  dir  = 1'($urandom_range(0, 1));
      int  n    = exp_sectors(1'b0, size);
      cart_ram_size = 8'(size);
      if (dir) pulse_load(); else pulse_save();
      run_transfer(dir, n, int'($urandom_range(1, 3)), int'($urandom_range(0, n - 1)),
                   1'($urandom_range(0, 1)));
      expect_idle("idle_after_random", 2);
      bk_ena = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
